stack_arbiter: RTL and testbench

- Shares one stack memory (push/pop/empty/address-reset interface) between two requesters:
  - requester 0: maze solver, which records and backtracks moves;
  - requester 1: path replay/dump unit.
- Serialises requests, grants round-robin and sequences the stack strobes with a fixed-latency wait.
- Tracks occupancy itself, so that illegal pops and pushes are rejected with an error instead of corrupting the stack pointer.

---
 rtl/stack_arbiter_pkg.sv | 24 ++
 rtl/stack_arbiter_if.sv | 40 ++++
 rtl/stack_arbiter_rr_pick2.sv | 20 ++
 rtl/stack_arbiter.sv | 145 ++++++++++++++
 tb/tb_stack_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_arbiter_pkg.sv
// Shared definitions for the two-requester stack arbiter: FSM encoding,
// op codes, requester indices and the grant legality helper.
package stack_arb_pkg;

    typedef enum logic [2:0] {
        ST_CLR,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // A pop on an empty stack or a push on a full one must never reach the stack.
    function automatic logic op_illegal(input logic op, input logic is_empty, input logic is_full);
        return ((op == OP_POP) && is_empty) || ((op == OP_PUSH) && is_full);
    endfunction

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester-side handshake and stack-side strobe bundle for stack_arbiter.
// The arbiter sits on the slave modport; the requesters/stack on master.
interface stack_arbiter_if #(
    parameter int N    = 2,
    parameter int SIZE = 16
) ();
    localparam int DW = $clog2(SIZE + 1);

    logic          clr;
    logic          req0;
    logic          req1;
    logic          op0;
    logic          op1;
    logic [N-1:0]  wdata0;
    logic [N-1:0]  wdata1;
    logic          ack0;
    logic          ack1;
    logic          err;
    logic [N-1:0]  rdata;
    logic [DW-1:0] depth;
    logic          busy;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_rst_adr;
    logic [N-1:0]  stk_din;
    logic [N-1:0]  stk_dout;

    modport slave (
        input  clr, req0, req1, op0, op1, wdata0, wdata1, stk_dout,
        output ack0, ack1, err, rdata, depth, busy,
               stk_push, stk_pop, stk_rst_adr, stk_din
    );

    modport master (
        output clr, req0, req1, op0, op1, wdata0, wdata1, stk_dout,
        input  ack0, ack1, err, rdata, depth, busy,
               stk_push, stk_pop, stk_rst_adr, stk_din
    );

endinterface

// File: rtl/stack_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// whichever requester was not granted last. Purely combinational.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one stack between two requesters: round-robin grant, fixed-latency
// strobe sequencing and local occupancy tracking that rejects illegal ops.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int N      = 2,
    parameter int SIZE   = 16,
    parameter int OP_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    stack_arbiter_if.slave bus
);

    localparam int DW = $clog2(SIZE + 1);
    localparam int CW = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;

    localparam logic [DW-1:0] DEPTH_FULL = DW'(SIZE);
    localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
    localparam logic [CW-1:0] CNT_INIT   = CW'(OP_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] depth_q;
    logic          last_grant_q;
    logic          gid_q;
    logic          gop_q;
    logic          gerr_q;
    logic [N-1:0]  din_q;
    logic [N-1:0]  rdata_q;

    logic          gnt_valid;
    logic          gnt_id;
    logic          sel_op;
    logic [N-1:0]  sel_wdata;
    logic          illegal;
    logic          grant_now;

    rr_pick2 u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        sel_op    = (gnt_id == REQ1) ? bus.op1    : bus.op0;
        sel_wdata = (gnt_id == REQ1) ? bus.wdata1 : bus.wdata0;
        illegal   = op_illegal(sel_op, depth_q == '0, depth_q == DEPTH_FULL);
        grant_now = (state_q == ST_IDLE) && !bus.clr && gnt_valid;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLR:   state_d = ST_IDLE;
            ST_IDLE: begin
                // clr outranks any pending request in the same cycle
                if (bus.clr) begin
                    state_d = ST_CLR;
                end else if (gnt_valid) begin
                    state_d = illegal ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_CLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            depth_q      <= '0;
            last_grant_q <= REQ1;
            gid_q        <= REQ0;
            gop_q        <= OP_POP;
            gerr_q       <= 1'b0;
            din_q        <= '0;
            rdata_q      <= '0;
        end else begin
            if (grant_now) begin
                gid_q  <= gnt_id;
                gop_q  <= sel_op;
                gerr_q <= illegal;
                if (!illegal) begin
                    din_q <= sel_wdata;
                end
            end
            case (state_q)
                ST_CLR:   depth_q <= '0;
                ST_ISSUE: cnt_q   <= CNT_INIT;
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        if (gop_q == OP_POP) begin
                            rdata_q <= bus.stk_dout;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // gerr_q already excludes pop-at-empty and push-at-full
                    if (!gerr_q) begin
                        if (gop_q == OP_PUSH) begin
                            depth_q <= depth_q + DEPTH_ONE;
                        end else begin
                            depth_q <= depth_q - DEPTH_ONE;
                        end
                    end
                    last_grant_q <= gid_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack0        = (state_q == ST_DONE) && (gid_q == REQ0);
    assign bus.ack1        = (state_q == ST_DONE) && (gid_q == REQ1);
    assign bus.err         = (state_q == ST_DONE) && gerr_q;
    assign bus.stk_push    = (state_q == ST_ISSUE) && (gop_q == OP_PUSH);
    assign bus.stk_pop     = (state_q == ST_ISSUE) && (gop_q == OP_POP);
    assign bus.stk_rst_adr = (state_q == ST_CLR);
    assign bus.stk_din     = din_q;
    assign bus.rdata       = rdata_q;
    assign bus.depth       = depth_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter with a behavioural stack and an ack scoreboard.
module tb_stack_arbiter;
    import stack_arb_pkg::*;

    localparam int N      = 2;
    localparam int SIZE   = 16;
    localparam int OP_LAT = 2;

    logic clk;
    logic rst;

    stack_arbiter_if #(.N(N), .SIZE(SIZE)) bus ();

    stack_arbiter #(.N(N), .SIZE(SIZE), .OP_LAT(OP_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       op;
        logic [1:0] wd;
        logic       err;
        logic [1:0] rd;
        int         dep;
        int         lat;
        int         clr_at;
    } vec_t;

    typedef struct {
        int         id;
        logic       err;
        logic       is_pop;
        logic [1:0] rd;
    } sb_t;

    vec_t vq[$];
    sb_t  sb[$];

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;
    int rsta_cnt = 0;
    int viol_cnt = 0;

    // Behavioural stack: data appears on stk_dout one edge after the strobe.
    logic [1:0] mem [SIZE];
    int         sp = 0;
    logic [1:0] dout_q = '0;
    assign bus.stk_dout = dout_q;

    always @(posedge clk) begin
        if (bus.stk_rst_adr) begin
            sp <= 0;
        end else if (bus.stk_push && sp < SIZE) begin
            mem[sp] <= bus.stk_din;
            sp      <= sp + 1;
            dout_q  <= bus.stk_din;
        end else if (bus.stk_pop && sp > 0) begin
            dout_q <= mem[sp-1];
            sp     <= sp - 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            push_cnt <= push_cnt + int'(bus.stk_push);
            pop_cnt  <= pop_cnt + int'(bus.stk_pop);
            rsta_cnt <= rsta_cnt + int'(bus.stk_rst_adr);
        end
    end

    always @(negedge clk) begin
        if ((int'(bus.stk_push) + int'(bus.stk_pop) + int'(bus.stk_rst_adr)) > 1) viol_cnt++;
    end

    task automatic check(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (bus.ack0 || bus.ack1)) begin
            sb_t e;
            check("ack_both", int'(bus.ack0 & bus.ack1), 0);
            if (sb.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL sb_unexpected_ack: got ack%0d expected none", int'(bus.ack1));
            end else begin
                e = sb.pop_front();
                check("ack_id", int'(bus.ack1), e.id);
                check("ack_err", int'(bus.err), int'(e.err));
                if (e.is_pop && !e.err) check("rdata", int'(bus.rdata), int'(e.rd));
            end
        end
    end

    function automatic void add(input int id, input logic op, input logic [1:0] wd,
                                input logic err, input logic [1:0] rd, input int dep,
                                input int lat, input int clr_at);
        vec_t v;
        v = '{id, op, wd, err, rd, dep, lat, clr_at};
        vq.push_back(v);
    endfunction

    task automatic run_txn(input vec_t v);
        int  lat;
        bit  got;
        int  p0, q0, r0;
        sb_t e;
        @(negedge clk);
        p0 = push_cnt; q0 = pop_cnt; r0 = rsta_cnt;
        e = '{v.id, v.err, (v.op == OP_POP), v.rd};
        sb.push_back(e);
        if (v.id == 0) begin
            bus.req0 = 1'b1; bus.op0 = v.op; bus.wdata0 = v.wd;
        end else begin
            bus.req1 = 1'b1; bus.op1 = v.op; bus.wdata1 = v.wd;
        end
        bus.clr = (v.clr_at == 0);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.clr = (lat == v.clr_at);
            got = (v.id == 0) ? bus.ack0 : bus.ack1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.clr  = 1'b0;
        check("ack_latency", got ? lat : -1, v.lat);
        @(posedge clk);
        @(negedge clk);
        check("depth", int'(bus.depth), v.dep);
        check("push_strobes", push_cnt - p0, (!v.err && v.op == OP_PUSH) ? 1 : 0);
        check("pop_strobes", pop_cnt - q0, (!v.err && v.op == OP_POP) ? 1 : 0);
        check("rst_adr_strobes", rsta_cnt - r0, (v.clr_at == 0) ? 1 : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, p0;
        rst = 1'b0;
        bus.clr = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0 = 1'b0; bus.op1 = 1'b0; bus.wdata0 = '0; bus.wdata1 = '0;

        // Reset state and release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack0", int'(bus.ack0), 0);
        check("rst_ack1", int'(bus.ack1), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_push", int'(bus.stk_push), 0);
        check("rst_pop", int'(bus.stk_pop), 0);
        check("rst_rdata", int'(bus.rdata), 0);
        check("rst_din", int'(bus.stk_din), 0);
        check("rst_busy", int'(bus.busy), 1);
        check("rst_rst_adr", int'(bus.stk_rst_adr), 1);
        check("rst_depth", int'(bus.depth), 0);
        rst = 1'b1;
        r0 = rsta_cnt;
        @(posedge clk);
        @(negedge clk);
        check("rel_rst_adr_cycles", rsta_cnt - r0, 1);
        check("rel_rst_adr", int'(bus.stk_rst_adr), 0);
        check("rel_busy", int'(bus.busy), 0);
        check("rel_depth", int'(bus.depth), 0);
        check("rel_no_strobes", push_cnt + pop_cnt, 0);

        // id, op, wdata, err, rdata, depth, latency, clr_at
        add(0, OP_PUSH, 2'b10, 0, 2'b00, 1, 4, -1);
        add(0, OP_POP,  2'b00, 0, 2'b10, 0, 4, -1);
        add(1, OP_POP,  2'b00, 1, 2'b00, 0, 1, -1);
        add(1, OP_PUSH, 2'b11, 0, 2'b00, 1, 4, -1);
        add(0, OP_PUSH, 2'b01, 0, 2'b00, 2, 4, -1);
        add(1, OP_POP,  2'b00, 0, 2'b01, 1, 4, -1);
        add(0, OP_POP,  2'b00, 0, 2'b11, 0, 4, -1);
        add(0, OP_POP,  2'b00, 1, 2'b00, 0, 1, -1);
        for (int i = 0; i < SIZE; i++) begin
            logic [1:0] d;
            d = 2'(i);
            add(i % 2, OP_PUSH, d, 0, 2'b00, i + 1, 4, -1);
        end
        add(0, OP_PUSH, 2'b11, 1, 2'b00, SIZE, 1, -1);
        // clr with a pending request: CLR first, then the request at depth 0
        add(1, OP_PUSH, 2'b11, 0, 2'b00, 1, 6, 0);
        // clr raised during WAIT has no effect
        add(0, OP_PUSH, 2'b10, 0, 2'b00, 2, 4, 2);
        add(1, OP_PUSH, 2'b01, 0, 2'b00, 3, 4, -1);
        add(1, OP_PUSH, 2'b00, 0, 2'b00, 4, 4, -1);
        add(1, OP_PUSH, 2'b11, 0, 2'b00, 5, 4, -1);
        add(1, OP_POP,  2'b00, 1, 2'b00, 0, 3, 0);

        foreach (vq[k]) run_txn(vq[k]);

        // Contention: both hold req for three transactions each, strict alternation
        for (int k = 0; k < 6; k++) begin
            sb_t e;
            e = '{k % 2, 1'b0, 1'b0, 2'b00};
            sb.push_back(e);
        end
        p0 = push_cnt;
        fork
            begin : rq0
                int n, guard;
                n = 0; guard = 0;
                @(negedge clk);
                bus.req0 = 1'b1; bus.op0 = OP_PUSH; bus.wdata0 = 2'b01;
                while (n < 3 && guard < 100) begin
                    @(posedge clk); guard++;
                    @(negedge clk);
                    if (bus.ack0) n++;
                end
                bus.req0 = 1'b0;
                check("cont_acks0", n, 3);
            end
            begin : rq1
                int n, guard;
                n = 0; guard = 0;
                @(negedge clk);
                bus.req1 = 1'b1; bus.op1 = OP_PUSH; bus.wdata1 = 2'b11;
                while (n < 3 && guard < 100) begin
                    @(posedge clk); guard++;
                    @(negedge clk);
                    if (bus.ack1) n++;
                end
                bus.req1 = 1'b0;
                check("cont_acks1", n, 3);
            end
        join
        @(posedge clk);
        @(negedge clk);
        check("cont_depth", int'(bus.depth), 6);
        check("cont_push_strobes", push_cnt - p0, 6);

        // Reset dropped during WAIT of a push
        @(negedge clk);
        bus.req0 = 1'b1; bus.op0 = OP_PUSH; bus.wdata0 = 2'b10;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ack0", int'(bus.ack0), 0);
        check("abort_push", int'(bus.stk_push), 0);
        check("abort_depth", int'(bus.depth), 0);
        check("abort_busy", int'(bus.busy), 1);
        check("abort_rst_adr", int'(bus.stk_rst_adr), 1);
        check("abort_din", int'(bus.stk_din), 0);
        bus.req0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        r0 = rsta_cnt;
        @(posedge clk);
        @(negedge clk);
        check("abort_clr_cycles", rsta_cnt - r0, 1);
        check("abort_idle", int'(bus.busy), 0);
        check("abort_depth_after", int'(bus.depth), 0);

        repeat (2) @(negedge clk);
        check("strobe_onehot_violations", viol_cnt, 0);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
